// File: rtl/bme280_sequencer.sv
// BME280 forced-mode measurement sequencer.
// Drives an i2c_master one transaction at a time. It writes ctrl_hum and then
// ctrl_meas, waits for the conversion, and reads 0xF7..0xFE byte by byte.
// It publishes the raw pressure, temperature and humidity words together with a
// single-cycle done pulse.
// All outputs are registered from the current state, so each output shows the
// state of the previous cycle.
module bme280_sequencer #(
  parameter logic [6:0] SLAVE_ADDR    = 7'h76,
  parameter logic [7:0] CTRL_HUM_VAL  = 8'h01,
  parameter logic [7:0] CTRL_MEAS_VAL = 8'h25,
  parameter int         TXN_CYCLES    = 128,
  parameter int         CONV_CYCLES   = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        i2c_en,
  output logic [6:0]  i2c_slave_address,
  output logic        i2c_read_write,
  output logic [7:0]  i2c_register_address,
  output logic [7:0]  i2c_data,
  input  logic [7:0]  i2c_rdata,
  output logic [19:0] press_raw,
  output logic [19:0] temp_raw,
  output logic [15:0] hum_raw
);

  localparam int CNT_MAX = (TXN_CYCLES > CONV_CYCLES) ? TXN_CYCLES : CONV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TXN_LAST  = CNT_W'(TXN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    WR_HUM_ISSUE  = 4'd1,
    WR_HUM_WAIT   = 4'd2,
    WR_MEAS_ISSUE = 4'd3,
    WR_MEAS_WAIT  = 4'd4,
    CONV_WAIT     = 4'd5,
    RD_ISSUE      = 4'd6,
    RD_WAIT       = 4'd7,
    DONE          = 4'd8
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic             capture_s;
  logic [7:0]       buf_r [8];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and the read-capture strobe.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = WR_HUM_ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_HUM_ISSUE:  state_next_s = WR_HUM_WAIT;
      WR_HUM_WAIT: begin
        if (cnt_r == TXN_LAST) begin
          state_next_s = WR_MEAS_ISSUE;
        end else begin
          state_next_s = WR_HUM_WAIT;
        end
      end
      WR_MEAS_ISSUE: state_next_s = WR_MEAS_WAIT;
      WR_MEAS_WAIT: begin
        if (cnt_r == TXN_LAST) begin
          state_next_s = CONV_WAIT;
        end else begin
          state_next_s = WR_MEAS_WAIT;
        end
      end
      CONV_WAIT: begin
        if (cnt_r == CONV_LAST) begin
          state_next_s = RD_ISSUE;
        end else begin
          state_next_s = CONV_WAIT;
        end
      end
      RD_ISSUE:      state_next_s = RD_WAIT;
      RD_WAIT: begin
        if (cnt_r == TXN_LAST) begin
          capture_s = 1'b1;
          if (idx_r == 3'd7) begin
            state_next_s = DONE;
          end else begin
            state_next_s = RD_ISSUE;
          end
        end else begin
          state_next_s = RD_WAIT;
        end
      end
      DONE:          state_next_s = IDLE;
      default:       state_next_s = IDLE;
    endcase
  end

  // Per-state cycle counter. It clears on every state change and stays at zero in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if ((state_next_s != state_r) || (state_r == IDLE)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Read byte index and byte buffer. i2c_rdata is only looked at on the capture strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        buf_r[i] <= 8'h00;
      end
    end else if ((state_r == IDLE) && start) begin
      idx_r <= 3'd0;
    end else if (capture_s) begin
      buf_r[idx_r] <= i2c_rdata;
      idx_r        <= idx_r + 3'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // I2C request bus. It loads on ISSUE states and otherwise holds, so it stays stable through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i2c_en               <= 1'b0;
      i2c_slave_address    <= SLAVE_ADDR;
      i2c_read_write       <= 1'b0;
      i2c_register_address <= 8'h00;
      i2c_data             <= 8'h00;
    end else begin
      i2c_en            <= (state_r == WR_HUM_ISSUE) || (state_r == WR_MEAS_ISSUE) ||
                           (state_r == RD_ISSUE);
      i2c_slave_address <= SLAVE_ADDR;
      case (state_r)
        WR_HUM_ISSUE: begin
          i2c_read_write       <= 1'b0;
          i2c_register_address <= 8'hF2;
          i2c_data             <= CTRL_HUM_VAL;
        end
        WR_MEAS_ISSUE: begin
          i2c_read_write       <= 1'b0;
          i2c_register_address <= 8'hF4;
          i2c_data             <= CTRL_MEAS_VAL;
        end
        RD_ISSUE: begin
          i2c_read_write       <= 1'b1;
          i2c_register_address <= 8'hF7 + {5'd0, idx_r};
          i2c_data             <= 8'h00;
        end
        default: begin
          i2c_read_write       <= i2c_read_write;
          i2c_register_address <= i2c_register_address;
          i2c_data             <= i2c_data;
        end
      endcase
    end
  end

  // Status flags and raw results. Results change only in the DONE cycle, and the low nibbles of 0xF9/0xFC are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      press_raw <= 20'h0;
      temp_raw  <= 20'h0;
      hum_raw   <= 16'h0;
    end else begin
      busy <= (state_r != IDLE) && (state_r != DONE);
      done <= (state_r == DONE);
      if (state_r == DONE) begin
        press_raw <= {buf_r[0], buf_r[1], buf_r[2][7:4]};
        temp_raw  <= {buf_r[3], buf_r[4], buf_r[5][7:4]};
        hum_raw   <= {buf_r[6], buf_r[7]};
      end else begin
        press_raw <= press_raw;
        temp_raw  <= temp_raw;
        hum_raw   <= hum_raw;
      end
    end
  end

endmodule

// File: tb/tb_bme280_sequencer.sv
// Directed bench for bme280_sequencer with short timing parameters.
// Expected I2C transactions are queued when start is driven and popped on each i2c_en pulse.
module tb_bme280_sequencer;

  localparam int TXN  = 4;
  localparam int CONV = 10;
  localparam int DONE_AT = 10 * (TXN + 1) + CONV + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        i2c_en;
  logic [6:0]  i2c_slave_address;
  logic        i2c_read_write;
  logic [7:0]  i2c_register_address;
  logic [7:0]  i2c_data;
  logic [7:0]  i2c_rdata;
  logic [19:0] press_raw;
  logic [19:0] temp_raw;
  logic [15:0] hum_raw;

  bme280_sequencer #(
    .SLAVE_ADDR(7'h76), .CTRL_HUM_VAL(8'h01), .CTRL_MEAS_VAL(8'h25),
    .TXN_CYCLES(TXN), .CONV_CYCLES(CONV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .i2c_en(i2c_en), .i2c_slave_address(i2c_slave_address),
    .i2c_read_write(i2c_read_write), .i2c_register_address(i2c_register_address),
    .i2c_data(i2c_data), .i2c_rdata(i2c_rdata),
    .press_raw(press_raw), .temp_raw(temp_raw), .hum_raw(hum_raw)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       rw;
    logic [7:0] ra;
    logic [7:0] wd;
  } txn_t;

  txn_t        exp_q[$];
  logic [19:0] exp_press;
  logic [19:0] exp_temp;
  logic [15:0] exp_hum;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_txn(input int cyc, input logic rw, input logic [7:0] ra, input logic [7:0] wd);
    txn_t t;
    t.cyc = cyc;
    t.rw  = rw;
    t.ra  = ra;
    t.wd  = wd;
    exp_q.push_back(t);
  endtask

  // Runs one measurement. It is entered just after a negedge. extra re-pulses start at
  // cycles 3 and DONE_AT, and abort_at>0 asserts rst in the middle of that cycle.
  task automatic run_meas(input logic [63:0] bytes, input bit extra, input int abort_at);
    txn_t t;
    int   en_cnt   = 0;
    int   done_cnt = 0;
    bit   aborted  = 1'b0;
    push_txn(1, 1'b0, 8'hF2, 8'h01);
    push_txn(6, 1'b0, 8'hF4, 8'h25);
    for (int k = 0; k < 8; k++) begin
      push_txn(21 + 5 * k, 1'b1, 8'hF7 + 8'(k), 8'h00);
    end
    start     = 1'b1;
    i2c_rdata = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    check("en_cycle0", {31'd0, i2c_en}, 32'd0);
    for (int n = 1; n <= DONE_AT; n++) begin
      start = (extra && (n == 3 || n == DONE_AT)) ? 1'b1 : 1'b0;
      if (n >= 25 && ((n - 25) % 5) == 0) begin
        i2c_rdata = bytes[63 - 8 * ((n - 25) / 5) -: 8];
      end else begin
        i2c_rdata = 8'($urandom);
      end
      if (n == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_en", {31'd0, i2c_en}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_press", {12'd0, press_raw}, 32'd0);
        check("abort_temp", {12'd0, temp_raw}, 32'd0);
        check("abort_hum", {16'd0, hum_raw}, 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        start   = 1'b0;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      if (i2c_en) begin
        en_cnt++;
        if (exp_q.size() == 0) begin
          check("en_unexpected_cycle", n, 32'd0);
        end else begin
          t = exp_q.pop_front();
          check("en_cycle", n, t.cyc);
          check("rw", {31'd0, i2c_read_write}, {31'd0, t.rw});
          check("reg", {24'd0, i2c_register_address}, {24'd0, t.ra});
          check("wdata", {24'd0, i2c_data}, {24'd0, t.wd});
          check("slave", {25'd0, i2c_slave_address}, 32'h76);
        end
      end
      if (done) begin
        done_cnt++;
      end
      check("done_timing", {31'd0, done}, {31'd0, (n == DONE_AT)});
      check("busy", {31'd0, busy}, {31'd0, (n < DONE_AT)});
      if (n < DONE_AT) begin
        check("press_hold", {12'd0, press_raw}, {12'd0, exp_press});
        check("hum_hold", {16'd0, hum_raw}, {16'd0, exp_hum});
      end
    end
    start = 1'b0;
    if (aborted) begin
      exp_q.delete();
      exp_press = 20'h0;
      exp_temp  = 20'h0;
      exp_hum   = 16'h0;
      check("abort_no_done", done_cnt, 32'd0);
    end else begin
      exp_press = {bytes[63:48], bytes[47:44]};
      exp_temp  = {bytes[39:24], bytes[23:20]};
      exp_hum   = bytes[15:0];
      check("press_raw", {12'd0, press_raw}, {12'd0, exp_press});
      check("temp_raw", {12'd0, temp_raw}, {12'd0, exp_temp});
      check("hum_raw", {16'd0, hum_raw}, {16'd0, exp_hum});
      check("en_count", en_cnt, 32'd10);
      check("done_count", done_cnt, 32'd1);
      check("queue_empty", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    i2c_rdata = 8'h00;
    exp_press = 20'h0;
    exp_temp  = 20'h0;
    exp_hum   = 16'h0;
    #12;
    rst = 1'b0;
    // Idle after reset: nothing moves and the address holds SLAVE_ADDR.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      i2c_rdata = 8'($urandom);
      check("idle_en", {31'd0, i2c_en}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_press", {12'd0, press_raw}, 32'd0);
    end
    check("reset_temp", {12'd0, temp_raw}, 32'd0);
    check("reset_hum", {16'd0, hum_raw}, 32'd0);
    check("reset_slave", {25'd0, i2c_slave_address}, 32'h76);
    check("reset_reg", {24'd0, i2c_register_address}, 32'd0);
    check("reset_data", {24'd0, i2c_data}, 32'd0);
    check("reset_rw", {31'd0, i2c_read_write}, 32'd0);

    // Reference bytes from the sensor datasheet example.
    run_meas(64'h655AC07EED006C3D, 1'b0, 0);
    repeat (3) @(negedge clk);
    // Start pulses while busy and in the DONE cycle are ignored. The start on the next cycle begins a new sequence.
    run_meas(64'h12345F6789AB1234, 1'b1, 0);
    run_meas(64'hA5C3FFFFFFFFBEEF, 1'b0, 0);
    repeat (2) @(negedge clk);
    // Reset lands during the fourth read. Nothing is published and the outputs are cleared.
    run_meas(64'h1111111111111111, 1'b0, 38);
    repeat (2) @(negedge clk);
    run_meas(64'h0F1E2D3C4B5A6978, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
